// File: rtl/padder_multirate_if.sv
// Message-word input, padded-block output and permutation handshake of the padder.
interface padder_multirate_if #(
  parameter int IN_W  = 32,
  parameter int R_MAX = 1152
);
  localparam int BN_W = (IN_W / 8 > 1) ? $clog2(IN_W / 8) : 1;

  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic             in_ready;
  logic             is_last;
  logic [BN_W-1:0]  byte_num;
  logic [1:0]       rate_sel;
  logic [7:0]       suffix;
  logic [R_MAX-1:0] out;
  logic             out_valid;
  logic             f_ack;
  logic             msg_done;

  // Source of message words and consumer of padded blocks.
  modport master (
    output in, in_valid, is_last, byte_num, rate_sel, suffix, f_ack,
    input  in_ready, out, out_valid, msg_done
  );

  // The padder itself.
  modport slave (
    input  in, in_valid, is_last, byte_num, rate_sel, suffix, f_ack,
    output in_ready, out, out_valid, msg_done
  );
endinterface

// File: rtl/padder_multirate.sv
// Multi-rate Keccak/SHA-3 padder: packs message words into a left-aligned
// rate block, appends the domain suffix and the final pad bit, and hands the
// block to the permutation through an out_valid / f_ack handshake.
module padder_multirate #(
  parameter int IN_W  = 32,
  parameter int R_MAX = 1152
) (
  input  logic              clk,
  input  logic              reset,
  padder_multirate_if.slave bus
);
  localparam int NB   = IN_W / 8;
  localparam int BN_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int K_W  = (R_MAX / IN_W > 1) ? $clog2(R_MAX / IN_W) : 1;

  typedef enum logic [1:0] {IDLE, ABSORB, FULL} state_t;

  state_t           state;
  logic [K_W-1:0]   k;
  logic             final_blk;
  logic [1:0]       rate_q;
  logic [7:0]       sfx_q;
  logic [R_MAX-1:0] blk;
  logic             out_valid_q;
  logic             msg_done_q;

  logic             xfer;
  logic [1:0]       sel_eff;
  logic [7:0]       sfx_eff;
  int               rate_eff;
  logic             last_word;
  logic [R_MAX-1:0] blk_wr;

  function automatic int rate_bits(input logic [1:0] sel);
    case (sel)
      2'd0:    return 1152;
      2'd1:    return 1088;
      2'd2:    return 832;
      default: return 576;
    endcase
  endfunction

  // Keep the leading nb message bytes, place the suffix right after them, zero the rest.
  function automatic logic [IN_W-1:0] pad_word(input logic [IN_W-1:0] w,
                                               input logic [BN_W-1:0] nb,
                                               input logic [7:0]      sfx);
    logic [IN_W-1:0] r;
    r = '0;
    for (int j = 0; j < NB; j++) begin
      if (j < int'(nb))       r[IN_W-1-8*j -: 8] = w[IN_W-1-8*j -: 8];
      else if (j == int'(nb)) r[IN_W-1-8*j -: 8] = sfx;
    end
    return r;
  endfunction

  // The permutation owns the block while it is FULL, so no word is taken then.
  assign bus.in_ready  = (state != FULL);
  assign xfer          = bus.in_valid && (state != FULL);
  assign bus.out       = blk;
  assign bus.out_valid = out_valid_q;
  assign bus.msg_done  = msg_done_q;

  // The first word of a message uses the live rate/suffix; later words use the latched copy.
  always_comb begin
    sel_eff   = (state == IDLE) ? bus.rate_sel : rate_q;
    sfx_eff   = (state == IDLE) ? bus.suffix : sfx_q;
    rate_eff  = rate_bits(sel_eff);
    last_word = (int'(k) == rate_eff / IN_W - 1);
    blk_wr    = blk;
    blk_wr[R_MAX-1-int'(k)*IN_W -: IN_W] =
      bus.is_last ? pad_word(bus.in, bus.byte_num, sfx_eff) : bus.in;
    // The closing pad bit sits in the last byte of the rate; OR keeps a suffix already there.
    if (bus.is_last)
      blk_wr[R_MAX-rate_eff +: 8] = blk_wr[R_MAX-rate_eff +: 8] | 8'h80;
  end

  // Absorb/hand-off FSM with the block register; reset discards any partial block at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      k           <= '0;
      final_blk   <= 1'b0;
      rate_q      <= 2'd0;
      sfx_q       <= 8'h00;
      blk         <= '0;
      out_valid_q <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      msg_done_q <= 1'b0;
      case (state)
        IDLE, ABSORB: begin
          if (xfer) begin
            blk <= blk_wr;
            if (state == IDLE) begin
              rate_q <= bus.rate_sel;
              sfx_q  <= bus.suffix;
            end
            if (bus.is_last) begin
              state       <= FULL;
              final_blk   <= 1'b1;
              out_valid_q <= 1'b1;
            end else if (last_word) begin
              state       <= FULL;
              final_blk   <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ABSORB;
              k     <= k + K_W'(1);
            end
          end
        end
        FULL: begin
          if (bus.f_ack) begin
            blk         <= '0;
            k           <= '0;
            out_valid_q <= 1'b0;
            final_blk   <= 1'b0;
            if (final_blk) begin
              state      <= IDLE;
              msg_done_q <= 1'b1;
            end else begin
              state <= ABSORB;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
